// File: rtl/servo_ramp_ctrl.sv
// Servo position ramp controller: steps pos_out toward a commanded target once per PWM frame.
// Define SERVO_RAMP_HOME_EN to add an idle timeout that ramps back to RESET_POS.
module servo_ramp_ctrl #(
    parameter int unsigned FRAME_LEN     = 1500,
    parameter int unsigned STEP          = 1,
    parameter int unsigned POS_MIN       = 0,
    parameter int unsigned POS_MAX       = 255,
    parameter int unsigned RESET_POS     = 75,
    parameter int unsigned SETTLE_FRAMES = 4,
    parameter int unsigned IDLE_FRAMES   = 50
) (
    input  logic       clkin,
    input  logic       rstn,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_pos,
    output logic       cmd_ready,
    output logic [7:0] pos_out,
    output logic       frame_tick,
    output logic       busy
);

    if (FRAME_LEN < 2 || FRAME_LEN > 8191 || STEP < 1 || STEP > 255 ||
        POS_MAX > 255 || POS_MIN > POS_MAX || RESET_POS < POS_MIN || RESET_POS > POS_MAX ||
        SETTLE_FRAMES > 255 || IDLE_FRAMES < 1 || IDLE_FRAMES > 65535) begin : g_param_check
        $fatal(1, "servo_ramp_ctrl: illegal parameter set");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRamp,
        StSettle
    } state_e;

    localparam logic [12:0] FrameLast  = 13'(FRAME_LEN - 1);
    localparam logic [8:0]  PosMin9    = 9'(POS_MIN);
    localparam logic [8:0]  PosMax9    = 9'(POS_MAX);
    localparam logic [7:0]  ResetPos   = 8'(RESET_POS);
    localparam logic [8:0]  Step9      = 9'(STEP);
    localparam logic [7:0]  SettleInit = 8'(SETTLE_FRAMES);

    state_e      state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic        frame_tick_q, frame_tick_d;
    logic [7:0]  pos_q, pos_d;
    logic [7:0]  target_q, target_d;
    logic [7:0]  settle_q, settle_d;

    logic        accept;
    logic        start;
    logic [7:0]  start_target;
    logic [7:0]  cmd_clamped;
    logic [8:0]  cmd9;
    logic [8:0]  below_min;
    logic [8:0]  above_max;
    logic [8:0]  pos9, tgt9, diff9, stepped9;

`ifdef SERVO_RAMP_HOME_EN
    localparam logic [15:0] IdleLimit = 16'(IDLE_FRAMES);
    logic [15:0] idle_q, idle_d;
    logic        timeout;
`endif

    assign cmd_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign pos_out    = pos_q;
    assign frame_tick = frame_tick_q;
    assign accept     = cmd_valid & cmd_ready;

    // The tick flop is loaded with the compare of the next count, so it is high
    // exactly while cnt_q sits at FRAME_LEN-1.
    always_comb begin
        cnt_d        = (cnt_q == FrameLast) ? 13'd0 : cnt_q + 13'd1;
        frame_tick_d = (cnt_d == FrameLast);
    end

    // Clamp via sign bits of 9-bit differences to avoid constant-range compares.
    always_comb begin
        cmd9      = {1'b0, cmd_pos};
        below_min = cmd9 - PosMin9;
        above_max = PosMax9 - cmd9;
        if (below_min[8]) begin
            cmd_clamped = PosMin9[7:0];
        end else if (above_max[8]) begin
            cmd_clamped = PosMax9[7:0];
        end else begin
            cmd_clamped = cmd_pos;
        end
    end

    // One ramp step at 9 bits: never wraps and never passes the target.
    always_comb begin
        pos9 = {1'b0, pos_q};
        tgt9 = {1'b0, target_q};
        if (tgt9 > pos9) begin
            diff9    = tgt9 - pos9;
            stepped9 = (diff9 <= Step9) ? tgt9 : pos9 + Step9;
        end else begin
            diff9    = pos9 - tgt9;
            stepped9 = (diff9 <= Step9) ? tgt9 : pos9 - Step9;
        end
    end

`ifdef SERVO_RAMP_HOME_EN
    assign timeout      = (state_q == StIdle) && (idle_q == IdleLimit) && !cmd_valid;
    assign start        = accept | timeout;
`else
    assign start        = accept;
`endif
    assign start_target = accept ? cmd_clamped : ResetPos;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        target_d = target_q;
        settle_d = settle_q;
`ifdef SERVO_RAMP_HOME_EN
        idle_d   = idle_q;
`endif
        case (state_q)
            StIdle: begin
`ifdef SERVO_RAMP_HOME_EN
                if (frame_tick_q) begin
                    idle_d = idle_q + 16'd1;
                end
`endif
                if (start) begin
                    target_d = start_target;
                    settle_d = SettleInit;
                    state_d  = (start_target != pos_q) ? StRamp : StSettle;
`ifdef SERVO_RAMP_HOME_EN
                    idle_d   = 16'd0;
`endif
                end
            end
            StRamp: begin
                if (frame_tick_q) begin
                    pos_d = stepped9[7:0];
                    if (stepped9[7:0] == target_q) begin
                        state_d  = StSettle;
                        settle_d = SettleInit;
                    end
                end
            end
            StSettle: begin
                if (frame_tick_q) begin
                    if (settle_q == 8'd0) begin
                        state_d = StIdle;
                    end else begin
                        settle_d = settle_q - 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clkin or posedge rstn) begin
        if (rstn) begin
            state_q      <= StIdle;
            cnt_q        <= 13'd0;
            frame_tick_q <= 1'b0;
            pos_q        <= ResetPos;
            target_q     <= ResetPos;
            settle_q     <= 8'd0;
`ifdef SERVO_RAMP_HOME_EN
            idle_q       <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            frame_tick_q <= frame_tick_d;
            pos_q        <= pos_d;
            target_q     <= target_d;
            settle_q     <= settle_d;
`ifdef SERVO_RAMP_HOME_EN
            idle_q       <= idle_d;
`endif
        end
    end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Scoreboard bench for servo_ramp_ctrl: per-frame expected position/busy pushed on command,
// popped and compared after every frame tick. A second instance uses POS_MAX=200.
`timescale 1ns/1ps
module tb_servo_ramp_ctrl;

    localparam int FrameLen     = 10;
    localparam int Step         = 5;
    localparam int SettleFrames = 2;
    localparam int IdleFrames   = 3;
    localparam int ResetPos     = 75;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_pos = 8'd0;

    logic       main_ready, main_tick, main_busy;
    logic [7:0] main_pos;
    logic       lim_ready, lim_tick, lim_busy;
    logic [7:0] lim_pos;

    always #5 clk = ~clk;

    servo_ramp_ctrl #(
        .FRAME_LEN    (FrameLen),
        .STEP         (Step),
        .SETTLE_FRAMES(SettleFrames),
        .IDLE_FRAMES  (IdleFrames)
    ) dut (
        .clkin     (clk),
        .rstn      (rst),
        .cmd_valid (cmd_valid),
        .cmd_pos   (cmd_pos),
        .cmd_ready (main_ready),
        .pos_out   (main_pos),
        .frame_tick(main_tick),
        .busy      (main_busy)
    );

    servo_ramp_ctrl #(
        .FRAME_LEN    (FrameLen),
        .STEP         (Step),
        .POS_MAX      (200),
        .SETTLE_FRAMES(SettleFrames),
        .IDLE_FRAMES  (IdleFrames)
    ) dut_lim (
        .clkin     (clk),
        .rstn      (rst),
        .cmd_valid (cmd_valid),
        .cmd_pos   (cmd_pos),
        .cmd_ready (lim_ready),
        .pos_out   (lim_pos),
        .frame_tick(lim_tick),
        .busy      (lim_busy)
    );

    typedef struct {
        int pos;
        bit busy;
    } exp_t;

    exp_t main_q[$];
    exp_t lim_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic push_exp(input bit lim, input exp_t e);
        if (lim) lim_q.push_back(e);
        else     main_q.push_back(e);
    endtask

    // Expected per-tick trajectory: ramp steps, then SettleFrames+1 ticks in settle.
    task automatic push_traj(input bit lim, input int from, input int tgt);
        int   p;
        exp_t e;
        p = from;
        while (p != tgt) begin
            if (tgt > p) p = (tgt - p <= Step) ? tgt : p + Step;
            else         p = (p - tgt <= Step) ? tgt : p - Step;
            e.pos  = p;
            e.busy = 1'b1;
            push_exp(lim, e);
        end
        for (int i = 0; i <= SettleFrames; i++) begin
            e.pos  = tgt;
            e.busy = (i != SettleFrames);
            push_exp(lim, e);
        end
    endtask

    task automatic push_hold(input bit lim, input int pos, input int n);
        exp_t e;
        e.pos  = pos;
        e.busy = 1'b0;
        for (int i = 0; i < n; i++) push_exp(lim, e);
    endtask

    task automatic pop_check(input bit lim);
        exp_t       e;
        logic [7:0] pos;
        logic       bsy, rdy;
        string      nm;
        nm = lim ? "lim" : "main";
        if (lim) begin
            check_eq({nm, "_sb_nonempty"}, lim_q.size() > 0, 1);
            if (lim_q.size() == 0) return;
            e   = lim_q.pop_front();
            pos = lim_pos;
            bsy = lim_busy;
            rdy = lim_ready;
        end else begin
            check_eq({nm, "_sb_nonempty"}, main_q.size() > 0, 1);
            if (main_q.size() == 0) return;
            e   = main_q.pop_front();
            pos = main_pos;
            bsy = main_busy;
            rdy = main_ready;
        end
        check_eq({nm, "_pos"}, pos, e.pos);
        check_eq({nm, "_busy"}, bsy, e.busy);
        check_eq({nm, "_ready"}, rdy, !e.busy);
    endtask

    // Returns at the negedge just after the edge that consumed a frame tick.
    task automatic wait_tick();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (main_tick !== 1'b1 && k < 4 * FrameLen);
        check_eq("tick_seen", main_tick, 1);
        check_eq("lim_tick_align", lim_tick, 1);
        @(negedge clk);
        check_eq("tick_width", main_tick, 0);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            wait_tick();
            pop_check(1'b0);
            pop_check(1'b1);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq({tag, "_pos"}, main_pos, ResetPos);
        check_eq({tag, "_lim_pos"}, lim_pos, ResetPos);
        check_eq({tag, "_ready"}, main_ready, 1);
        check_eq({tag, "_busy"}, main_busy, 0);
        check_eq({tag, "_tick"}, main_tick, 0);
        main_q.delete();
        lim_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_cmd(input int pos, input int exp_pos);
        cmd_valid = 1'b1;
        cmd_pos   = 8'(pos);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_pos   = 8'd0;
        check_eq("accept_busy", main_busy, 1);
        check_eq("accept_lim_busy", lim_busy, 1);
        check_eq("accept_pos", main_pos, exp_pos);
        check_eq("accept_lim_pos", lim_pos, exp_pos);
    endtask

    initial begin
        int edges;
        int k;

        // Reset state and first tick position after release.
        do_reset("reset");
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (main_tick !== 1'b1 && edges < 4 * FrameLen);
        check_eq("first_tick_edges", edges, FrameLen - 1);

        // Command equal to current position, accepted on a tick cycle: straight to settle.
        send_cmd(75, 75);
        push_traj(1'b0, 75, 75);
        push_traj(1'b1, 75, 75);
        run_ticks(3);

        // Small move within one step.
        send_cmd(73, 75);
        push_traj(1'b0, 75, 73);
        push_traj(1'b1, 75, 73);
        run_ticks(4);

        // Ramp to 100 with ignored commands mid-ramp.
        do_reset("reset2");
        send_cmd(100, 75);
        push_traj(1'b0, 75, 100);
        push_traj(1'b1, 75, 100);
        run_ticks(2);
        cmd_valid = 1'b1;
        cmd_pos   = 8'd10;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        cmd_pos   = 8'd0;
        run_ticks(6);

        // Clamp: main ramps toward 250, limited instance stops at 200; then reset mid-ramp.
        do_reset("reset3");
        send_cmd(250, 75);
        push_traj(1'b0, 75, 250);
        push_traj(1'b1, 75, 200);
        run_ticks(28);
        do_reset("reset_midramp");

        // Accept on a tick cycle, then idle behaviour.
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (main_tick !== 1'b1 && k < 4 * FrameLen);
        check_eq("tick_before_cmd", main_tick, 1);
        send_cmd(120, 75);
        push_traj(1'b0, 75, 120);
        push_traj(1'b1, 75, 120);
`ifdef SERVO_RAMP_HOME_EN
        push_hold(1'b0, 120, IdleFrames);
        push_hold(1'b1, 120, IdleFrames);
        push_traj(1'b0, 120, ResetPos);
        push_traj(1'b1, 120, ResetPos);
        run_ticks(27);
`else
        push_hold(1'b0, 120, 20);
        push_hold(1'b1, 120, 20);
        run_ticks(32);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
